// File: rtl/fpu_div_iter_if.sv
// -----------------------------------------------------------------------------
// fpu_div_iter_if
// Handshake and operand/result bundle for the iterative mantissa divider.
//   master : requester side (drives Start/Kill and operands, reads results)
//   slave  : divider side
// Signals:
//   Start_SI, Kill_SI            request / abort
//   Mant_a_DI, Mant_b_DI         mantissas with hidden bit (C_MANT+1)
//   Exp_a_DI, Exp_b_DI           biased exponents (C_EXP)
//   Sign_a_DI, Sign_b_DI         operand signs
//   Ready_SO, Valid_SO           accept-ready, one-cycle result strobe
//   Mant_div_DO                  quotient, xx.x format (C_MANT_PRENORM)
//   Exp_div_DO                   signed quotient exponent (C_EXP_PRENORM)
//   Sign_div_DO, Div_zero_SO     quotient sign, divide-by-zero flag
// -----------------------------------------------------------------------------
interface fpu_div_iter_if #(
   parameter int C_MANT         = 23,
   parameter int C_EXP          = 8,
   parameter int C_MANT_PRENORM = 48,
   parameter int C_EXP_PRENORM  = 10
);
   logic                             Start_SI;
   logic                             Kill_SI;
   logic [C_MANT:0]                  Mant_a_DI;
   logic [C_MANT:0]                  Mant_b_DI;
   logic [C_EXP-1:0]                 Exp_a_DI;
   logic [C_EXP-1:0]                 Exp_b_DI;
   logic                             Sign_a_DI;
   logic                             Sign_b_DI;
   logic                             Ready_SO;
   logic                             Valid_SO;
   logic [C_MANT_PRENORM-1:0]        Mant_div_DO;
   logic signed [C_EXP_PRENORM-1:0]  Exp_div_DO;
   logic                             Sign_div_DO;
   logic                             Div_zero_SO;

   modport master (
      output Start_SI, Kill_SI, Mant_a_DI, Mant_b_DI, Exp_a_DI, Exp_b_DI,
             Sign_a_DI, Sign_b_DI,
      input  Ready_SO, Valid_SO, Mant_div_DO, Exp_div_DO, Sign_div_DO, Div_zero_SO
   );

   modport slave (
      input  Start_SI, Kill_SI, Mant_a_DI, Mant_b_DI, Exp_a_DI, Exp_b_DI,
             Sign_a_DI, Sign_b_DI,
      output Ready_SO, Valid_SO, Mant_div_DO, Exp_div_DO, Sign_div_DO, Div_zero_SO
   );
endinterface

// File: rtl/fpu_div_iter.sv
// -----------------------------------------------------------------------------
// fpu_div_iter
// Restoring radix-2 mantissa divider: one quotient bit per clock, 27 bits
// (integer bit + 26 fraction bits) plus a sticky bit, packed for the
// post-normaliser. Zero divisors finish immediately with Div_zero_SO set.
// Ports:
//   Clk_CI   clock (rising edge)
//   Rst_RI   synchronous active-high reset
//   bus      fpu_div_iter_if.slave: Start/Kill/operands in, Ready/Valid/result out
// -----------------------------------------------------------------------------
module fpu_div_iter #(
   parameter int C_MANT         = 23,
   parameter int C_EXP          = 8,
   parameter int C_MANT_PRENORM = 48,
   parameter int C_EXP_PRENORM  = 10,
   parameter int C_BIAS         = 127
) (
   input  logic          Clk_CI,
   input  logic          Rst_RI,
   fpu_div_iter_if.slave bus
);

   localparam int C_REM = C_MANT + 3;                     // remainder width
   localparam int C_QUO = C_MANT + 4;                     // quotient bits
   localparam int C_PAD = C_MANT_PRENORM - C_QUO - 2;     // zero fill below sticky
   localparam logic [4:0] C_CNT_INIT = 5'(C_QUO - 1);

   typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

   state_t                           r_state;
   logic                             r_ready;
   logic                             r_valid;
   logic [4:0]                       r_cnt;
   logic [C_REM-1:0]                 r_rem;
   logic [C_MANT:0]                  r_mb;
   logic [C_QUO-1:0]                 r_q;
   logic                             r_sign;
   logic signed [C_EXP_PRENORM-1:0]  r_exp;
   logic [C_MANT_PRENORM-1:0]        r_mant_out;
   logic signed [C_EXP_PRENORM-1:0]  r_exp_out;
   logic                             r_sign_out;
   logic                             r_dz_out;

   logic                             w_ge;
   logic [C_REM-1:0]                 w_rem_sub;
   logic [C_REM-1:0]                 w_rem_next;
   logic [C_QUO-1:0]                 w_q_next;
   logic signed [C_EXP_PRENORM-1:0]  w_ea;
   logic signed [C_EXP_PRENORM-1:0]  w_eb;
   logic signed [C_EXP_PRENORM-1:0]  w_exp;

   // Quotient word: leading zero, 27 quotient bits, sticky, zero fill.
   function automatic logic [C_MANT_PRENORM-1:0] pack_mant(input logic [C_QUO-1:0] q,
                                                          input logic sticky);
      return {1'b0, q, sticky, {C_PAD{1'b0}}};
   endfunction

   always_comb begin
      w_ge       = (r_rem >= {2'b00, r_mb});
      w_rem_sub  = w_ge ? (r_rem - {2'b00, r_mb}) : r_rem;
      // After a subtract the remainder is below the divisor, so the shift
      // never loses a set bit.
      w_rem_next = w_rem_sub << 1;
      w_q_next   = {r_q[C_QUO-2:0], w_ge};
      w_ea       = $signed({{(C_EXP_PRENORM-C_EXP){1'b0}}, bus.Exp_a_DI});
      w_eb       = $signed({{(C_EXP_PRENORM-C_EXP){1'b0}}, bus.Exp_b_DI});
      w_exp      = w_ea - w_eb + C_EXP_PRENORM'(C_BIAS);
   end

   always_ff @(posedge Clk_CI) begin
      if (Rst_RI) begin
         r_state    <= IDLE;
         r_ready    <= 1'b1;
         r_valid    <= 1'b0;
         r_cnt      <= '0;
         r_rem      <= '0;
         r_mb       <= '0;
         r_q        <= '0;
         r_sign     <= 1'b0;
         r_exp      <= '0;
         r_mant_out <= '0;
         r_exp_out  <= '0;
         r_sign_out <= 1'b0;
         r_dz_out   <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         case (r_state)
            IDLE, DONE: begin
               if (bus.Start_SI) begin
                  r_sign <= bus.Sign_a_DI ^ bus.Sign_b_DI;
                  r_exp  <= w_exp;
                  r_mb   <= bus.Mant_b_DI;
                  r_rem  <= {2'b00, bus.Mant_a_DI};
                  r_q    <= '0;
                  r_cnt  <= C_CNT_INIT;
                  if (bus.Mant_b_DI == '0) begin
                     // Zero divisor: publish the flagged result straight away.
                     r_state    <= DONE;
                     r_ready    <= 1'b1;
                     r_valid    <= 1'b1;
                     r_mant_out <= '0;
                     r_exp_out  <= w_exp;
                     r_sign_out <= bus.Sign_a_DI ^ bus.Sign_b_DI;
                     r_dz_out   <= 1'b1;
                  end else begin
                     r_state <= CALC;
                     r_ready <= 1'b0;
                  end
               end else begin
                  r_state <= IDLE;
                  r_ready <= 1'b1;
               end
            end
            CALC: begin
               if (bus.Kill_SI) begin
                  // Abort wins over a finishing iteration; results stay untouched.
                  r_state <= IDLE;
                  r_ready <= 1'b1;
               end else begin
                  r_rem <= w_rem_next;
                  r_q   <= w_q_next;
                  r_cnt <= r_cnt - 5'd1;
                  if (r_cnt == '0) begin
                     r_state    <= DONE;
                     r_ready    <= 1'b1;
                     r_valid    <= 1'b1;
                     r_mant_out <= pack_mant(w_q_next, w_rem_next != '0);
                     r_exp_out  <= r_exp;
                     r_sign_out <= r_sign;
                     r_dz_out   <= 1'b0;
                  end
               end
            end
            default: begin
               r_state <= IDLE;
               r_ready <= 1'b1;
            end
         endcase
      end
   end

   assign bus.Ready_SO    = r_ready;
   assign bus.Valid_SO    = r_valid;
   assign bus.Mant_div_DO = r_mant_out;
   assign bus.Exp_div_DO  = r_exp_out;
   assign bus.Sign_div_DO = r_sign_out;
   assign bus.Div_zero_SO = r_dz_out;

endmodule

// File: tb/tb_fpu_div_iter.sv
// -----------------------------------------------------------------------------
// tb_fpu_div_iter
// Directed vector table for the iterative divider plus hand-written sequences
// for kill, back-to-back start and mid-calculation reset.
// -----------------------------------------------------------------------------
module tb_fpu_div_iter;

   logic Clk_CI = 1'b0;
   logic Rst_RI = 1'b1;

   fpu_div_iter_if bus ();

   fpu_div_iter dut (
      .Clk_CI (Clk_CI),
      .Rst_RI (Rst_RI),
      .bus    (bus)
   );

   always #5 Clk_CI = ~Clk_CI;

   typedef struct {
      logic [23:0]       ma;
      logic [23:0]       mb;
      logic [7:0]        ea;
      logic [7:0]        eb;
      logic              sa;
      logic              sb;
      logic [47:0]       mant;
      logic signed [9:0] ex;
      logic              sg;
      logic              dz;
      int                lat;
   } vec_t;

   vec_t vecs [8];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge Clk_CI);
      #1;
   endtask

   task automatic drive_ops(input vec_t v);
      bus.Mant_a_DI = v.ma;
      bus.Mant_b_DI = v.mb;
      bus.Exp_a_DI  = v.ea;
      bus.Exp_b_DI  = v.eb;
      bus.Sign_a_DI = v.sa;
      bus.Sign_b_DI = v.sb;
   endtask

   // Waits for Valid_SO; lat counts cycles since the accept edge (1 = the
   // cycle right after it). Gives up after 40 cycles.
   task automatic wait_valid(output int lat);
      lat = 1;
      while (!bus.Valid_SO && lat < 40) begin
         tick();
         lat++;
      end
   endtask

   task automatic chk_result(input string tag, input vec_t v);
      chk({tag, "_mant"}, 64'(bus.Mant_div_DO), 64'(v.mant));
      chk({tag, "_exp"},  64'(bus.Exp_div_DO),  64'(v.ex));
      chk({tag, "_sign"}, 64'(bus.Sign_div_DO), 64'(v.sg));
      chk({tag, "_dz"},   64'(bus.Div_zero_SO), 64'(v.dz));
   endtask

   task automatic run_op(input string tag, input vec_t v);
      int lat;
      drive_ops(v);
      bus.Start_SI = 1'b1;
      tick();
      bus.Start_SI = 1'b0;
      wait_valid(lat);
      chk({tag, "_lat"}, 64'(lat), 64'(v.lat));
      chk_result(tag, v);
      chk({tag, "_rdy_done"}, 64'(bus.Ready_SO), 64'd1);
      tick();
      chk({tag, "_valid_1cyc"}, 64'(bus.Valid_SO), 64'd0);
   endtask

   initial begin
      int lat;
      int nvalid;

      //            ma         mb         ea      eb      sa    sb    mant               ex              sg    dz    lat
      vecs[0] = '{24'h800000, 24'h800000, 8'd127, 8'd127, 1'b0, 1'b0, 48'h400000000000, 10'sd127,  1'b0, 1'b0, 28};
      vecs[1] = '{24'h800000, 24'hC00000, 8'd127, 8'd127, 1'b0, 1'b1, 48'h2AAAAAA80000, 10'sd127,  1'b1, 1'b0, 28};
      vecs[2] = '{24'h800000, 24'h000000, 8'd1,   8'd254, 1'b0, 1'b0, 48'h000000000000, -10'sd126,  1'b0, 1'b1, 1};
      vecs[3] = '{24'hC00000, 24'h800000, 8'd130, 8'd127, 1'b1, 1'b1, 48'h600000000000, 10'sd130,  1'b0, 1'b0, 28};
      vecs[4] = '{24'h000000, 24'h800000, 8'd0,   8'd127, 1'b1, 1'b0, 48'h000000000000, 10'sd0,    1'b1, 1'b0, 28};
      vecs[5] = '{24'hFFFFFF, 24'h800000, 8'd254, 8'd1,   1'b0, 1'b0, 48'h7FFFFF800000, 10'sd380,  1'b0, 1'b0, 28};
      vecs[6] = '{24'h800000, 24'hFFFFFF, 8'd0,   8'd254, 1'b0, 1'b1, 48'h200000280000, -10'sd127,  1'b1, 1'b0, 28};
      vecs[7] = '{24'h000000, 24'h000000, 8'd10,  8'd20,  1'b1, 1'b1, 48'h000000000000, 10'sd117,  1'b0, 1'b1, 1};

      bus.Start_SI = 1'b0;
      bus.Kill_SI  = 1'b0;
      drive_ops(vecs[0]);

      // Reset state
      tick();
      tick();
      Rst_RI = 1'b0;
      chk("rst_ready", 64'(bus.Ready_SO),    64'd1);
      chk("rst_valid", 64'(bus.Valid_SO),    64'd0);
      chk("rst_mant",  64'(bus.Mant_div_DO), 64'd0);
      chk("rst_exp",   64'(bus.Exp_div_DO),  64'd0);
      chk("rst_sign",  64'(bus.Sign_div_DO), 64'd0);
      chk("rst_dz",    64'(bus.Div_zero_SO), 64'd0);

      // Directed vector table
      for (int i = 0; i < 8; i++) begin
         run_op($sformatf("vec%0d", i), vecs[i]);
      end

      // Kill ten cycles into CALC; previous result (vecs[7]) must survive
      drive_ops(vecs[1]);
      bus.Start_SI = 1'b1;
      tick();
      bus.Start_SI = 1'b0;
      chk("kill_busy", 64'(bus.Ready_SO), 64'd0);
      repeat (10) tick();
      bus.Kill_SI = 1'b1;
      tick();
      bus.Kill_SI = 1'b0;
      chk("kill_ready", 64'(bus.Ready_SO), 64'd1);
      chk("kill_valid", 64'(bus.Valid_SO), 64'd0);
      nvalid = 0;
      for (int c = 0; c < 35; c++) begin
         if (bus.Valid_SO) nvalid++;
         tick();
      end
      chk("kill_no_valid", 64'(nvalid), 64'd0);
      chk_result("kill_hold", vecs[7]);
      run_op("after_kill", vecs[0]);

      // Start held high across two operations
      drive_ops(vecs[1]);
      bus.Start_SI = 1'b1;
      tick();
      drive_ops(vecs[3]);
      wait_valid(lat);
      chk("b2b_lat1", 64'(lat), 64'd28);
      chk_result("b2b_first", vecs[1]);
      tick();
      bus.Start_SI = 1'b0;
      chk("b2b_reaccept", 64'(bus.Ready_SO), 64'd0);
      wait_valid(lat);
      chk("b2b_lat2", 64'(lat), 64'd28);
      chk_result("b2b_second", vecs[3]);
      tick();

      // Reset mid-CALC, with a competing Start in the reset cycle
      drive_ops(vecs[1]);
      bus.Start_SI = 1'b1;
      tick();
      bus.Start_SI = 1'b0;
      repeat (5) tick();
      drive_ops(vecs[0]);
      bus.Start_SI = 1'b1;
      Rst_RI       = 1'b1;
      tick();
      Rst_RI       = 1'b0;
      bus.Start_SI = 1'b0;
      chk("mrst_ready", 64'(bus.Ready_SO),    64'd1);
      chk("mrst_valid", 64'(bus.Valid_SO),    64'd0);
      chk("mrst_mant",  64'(bus.Mant_div_DO), 64'd0);
      chk("mrst_exp",   64'(bus.Exp_div_DO),  64'd0);
      chk("mrst_sign",  64'(bus.Sign_div_DO), 64'd0);
      chk("mrst_dz",    64'(bus.Div_zero_SO), 64'd0);
      nvalid = 0;
      for (int c = 0; c < 35; c++) begin
         if (bus.Valid_SO) nvalid++;
         tick();
      end
      chk("mrst_no_valid", 64'(nvalid), 64'd0);
      chk("mrst_idle", 64'(bus.Ready_SO), 64'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fpu_div_iter.md
FPU_DIV_ITER -- requirements
Module: fpu_div_iter

Interface
REQ-001 Parameter C_MANT, 23, mantissa width without hidden bit, taken from fpu_defs.
REQ-002 Parameter C_EXP, 8, exponent field width, taken from fpu_defs.
REQ-003 Parameter C_MANT_PRENORM, 48, prenormalised mantissa width, matching the normaliser input.
REQ-004 Parameter C_EXP_PRENORM, 10, signed prenormalised exponent width.
REQ-005 Parameter C_BIAS, 127, exponent bias.
REQ-006 Clk_CI  in  1  clock; one clock domain, all state updates on its rising edge.
REQ-007 Rst_RI  in  1  reset, synchronous, active-high.
REQ-008 Start_SI  in  1  request; accepted only while Ready_SO=1.
REQ-009 Kill_SI  in  1  abort of an in-flight division.
REQ-010 Mant_a_DI, Mant_b_DI  in  C_MANT+1 each  dividend and divisor mantissas, hidden bit included.
REQ-011 Exp_a_DI, Exp_b_DI  in  C_EXP each  biased exponents.
REQ-012 Sign_a_DI, Sign_b_DI  in  1 each  operand signs.
REQ-013 Ready_SO  out  1  block can accept Start_SI this cycle.
REQ-014 Valid_SO  out  1  one-cycle result strobe.
REQ-015 Mant_div_DO  out  C_MANT_PRENORM  quotient in xx.x format, binary point between bits 46 and 45.
REQ-016 Exp_div_DO  out  C_EXP_PRENORM signed  quotient exponent.
REQ-017 Sign_div_DO  out  1  quotient sign.
REQ-018 Div_zero_SO  out  1  divisor mantissa was zero.

Function
REQ-019 FSM states: IDLE, CALC, DONE. Ready_SO=1 in IDLE and DONE and 0 in CALC.
REQ-020 On an accepted Start_SI, the block registers both operands, Sign_div = Sign_a^Sign_b and Exp_div = Exp_a - Exp_b + C_BIAS, computed in signed C_EXP_PRENORM width.
REQ-021 Accept with Mant_b_DI=0: next state DONE with Div_zero_SO=1, Mant_div_DO=0 and no CALC cycles.
REQ-022 Accept with Mant_b_DI!=0: remainder R=Mant_a (C_MANT+3 bits), counter=26, next state CALC.
REQ-023 Each CALC cycle produces one quotient bit, MSB first: if R>=Mb then q=1 and R=R-Mb, else q=0; then R=R<<1; the counter decrements.
REQ-024 After 27 CALC cycles, at counter=0, Q=floor(Ma*2^26/Mb) (27 bits) and the next state is DONE.
REQ-025 Result packing: Mant_div_DO = {1'b0, Q[26:0], sticky, 19'b0}, where sticky = (final R != 0).
REQ-026 Valid_SO=1 for exactly the single DONE cycle; the state returns to IDLE unless Start_SI is accepted in that cycle.
REQ-027 Latency: for a nonzero divisor, Valid_SO rises 28 cycles after the accept edge; for a zero divisor, 1 cycle after.
REQ-028 Mant_div_DO, Exp_div_DO, Sign_div_DO and Div_zero_SO are registered and hold their values from DONE until the next result is written.
REQ-029 Start_SI in CALC is ignored; no queuing.
REQ-030 Start_SI in DONE is accepted (back-to-back operation); the new operation follows REQ-020..REQ-022.
REQ-031 Kill_SI in CALC: next state IDLE, no Valid_SO, outputs keep their previous values; Kill_SI has priority over iteration completion.
REQ-032 Kill_SI in IDLE or DONE has no effect; Start_SI with Kill_SI in the same cycle is accepted.
REQ-033 Precondition: Mant_a_DI is zero or has bit C_MANT set, and Mant_b_DI is zero or has bit C_MANT set; behaviour for other inputs is undefined.
REQ-034 Mant_a_DI=0 with Mant_b_DI!=0 runs the full iteration and yields Mant_div_DO=0, sticky=0.

Reset
REQ-035 Rst_RI=1 at a clock edge forces IDLE, Ready_SO=1, Valid_SO=0, Div_zero_SO=0, all data outputs and internal registers to 0, from any state, including mid-CALC.
REQ-036 Start_SI is ignored in a cycle where Rst_RI=1.

Verification
REQ-037 1.0/1.0 (Ma=Mb=0x800000, Ea=Eb=127, signs 0/0) -> Valid_SO 28 cycles after the accept edge; Mant_div_DO=0x400000000000, Exp_div_DO=127, Sign_div_DO=0, Div_zero_SO=0.
REQ-038 1.0/-1.5 (Mb=0xC00000, Sign_b=1) -> Q=0x2AAAAAA, sticky=1, Mant_div_DO=0x2AAAAAA80000, Exp_div_DO=127, Sign_div_DO=1.
REQ-039 Mant_b_DI=0 -> Valid_SO 1 cycle after accept, Div_zero_SO=1, Mant_div_DO=0; Ea=1, Eb=254 -> Exp_div_DO=-126.
REQ-040 Kill_SI 10 cycles into CALC -> no Valid_SO, Ready_SO=1 next cycle; a subsequent 1.0/1.0 gives the REQ-037 result.
REQ-041 Start_SI held high across two operations -> second accepted in the first DONE cycle; two Valid_SO strobes 28 cycles apart, second result correct.
REQ-042 Rst_RI pulsed mid-CALC -> all outputs 0 and Ready_SO=1 after the edge; no Valid_SO from the aborted operation.
